// File: rtl/piece_move_sequencer.sv
// Sequencer that turns gravity ticks, hard-drop and player move/rotate requests into one
// candidate (x,y,rot) at a time for the collision checker. Optional wall kicks: WALL_KICK_EN.
module piece_move_sequencer #(
    parameter int BITS_X_POS = 4,
    parameter int BITS_Y_POS = 5,
    parameter int BITS_ROT   = 2,
    parameter int NUM_KICKS  = 4,
    parameter int MODE_BITS  = 2,
    parameter logic [MODE_BITS-1:0] MODE_PLAY = MODE_BITS'(1),
    parameter logic [MODE_BITS-1:0] MODE_DROP = MODE_BITS'(2)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [MODE_BITS-1:0]  mode,
    input  logic                  game_clk,
    input  logic                  mv_left,
    input  logic                  mv_right,
    input  logic                  mv_rot,
    input  logic [BITS_X_POS-1:0] cur_pos_x,
    input  logic [BITS_Y_POS-1:0] cur_pos_y,
    input  logic [BITS_ROT-1:0]   cur_rot,
    output logic [BITS_X_POS-1:0] test_pos_x,
    output logic [BITS_Y_POS-1:0] test_pos_y,
    output logic [BITS_ROT-1:0]   test_rot,
    output logic                  test_valid,
    input  logic                  test_done,
    input  logic                  test_ok,
    output logic                  upd_valid,
    output logic                  lock,
    output logic                  busy
);

`ifdef WALL_KICK_EN
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_COMMIT, S_LOCK, S_KICK} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_COMMIT, S_LOCK} state_t;
`endif
    typedef enum logic [1:0] {OP_DOWN, OP_LEFT, OP_RIGHT, OP_ROT} op_t;

    state_t                state_reg, state_next;
    op_t                   op_reg, op_next;
    logic                  tick_pend_reg, tick_pend_next;
    logic [BITS_X_POS-1:0] test_x_reg, test_x_next;
    logic [BITS_Y_POS-1:0] test_y_reg, test_y_next;
    logic [BITS_ROT-1:0]   test_rot_reg, test_rot_next;
    logic                  test_valid_reg, test_valid_next;
    logic                  mode_active;

`ifdef WALL_KICK_EN
    logic [2:0]            kick_idx_reg, kick_idx_next;
    logic [BITS_X_POS-1:0] kick_off [4];

    // Kick x offsets in try order: +1, -1, +2, -2 (two's complement, wraps with the field)
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_kick_off
            localparam int MAG = gi / 2 + 1;
            assign kick_off[gi] = (gi % 2 == 0) ? BITS_X_POS'(MAG) : BITS_X_POS'(-MAG);
        end
    endgenerate
`else
    logic [2:0] unused_num_kicks;
    assign unused_num_kicks = 3'(NUM_KICKS);
`endif

    assign mode_active = (mode == MODE_PLAY) || (mode == MODE_DROP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            op_reg         <= OP_DOWN;
            tick_pend_reg  <= 1'b0;
            test_x_reg     <= '0;
            test_y_reg     <= '0;
            test_rot_reg   <= '0;
            test_valid_reg <= 1'b0;
`ifdef WALL_KICK_EN
            kick_idx_reg   <= '0;
`endif
        end else begin
            state_reg      <= state_next;
            op_reg         <= op_next;
            tick_pend_reg  <= tick_pend_next;
            test_x_reg     <= test_x_next;
            test_y_reg     <= test_y_next;
            test_rot_reg   <= test_rot_next;
            test_valid_reg <= test_valid_next;
`ifdef WALL_KICK_EN
            kick_idx_reg   <= kick_idx_next;
`endif
        end
    end

    always_comb begin
        state_next      = state_reg;
        op_next         = op_reg;
        tick_pend_next  = tick_pend_reg;
        test_x_next     = test_x_reg;
        test_y_next     = test_y_reg;
        test_rot_next   = test_rot_reg;
        test_valid_next = test_valid_reg;
`ifdef WALL_KICK_EN
        kick_idx_next   = kick_idx_reg;
`endif
        case (state_reg)
            S_IDLE: begin
`ifdef WALL_KICK_EN
                kick_idx_next = '0;
`endif
                if (!mode_active) begin
                    test_x_next   = cur_pos_x;
                    test_y_next   = cur_pos_y;
                    test_rot_next = cur_rot;
                end else if (mode == MODE_DROP) begin
                    // Drop wins; a coincident gravity tick is remembered, not lost
                    op_next    = OP_DOWN;
                    state_next = S_ISSUE;
                    if (game_clk) tick_pend_next = 1'b1;
                end else if (tick_pend_reg || game_clk) begin
                    op_next        = OP_DOWN;
                    state_next     = S_ISSUE;
                    tick_pend_next = 1'b0;
                end else if (mv_rot) begin
                    op_next    = OP_ROT;
                    state_next = S_ISSUE;
                end else if (mv_left) begin
                    op_next    = OP_LEFT;
                    state_next = S_ISSUE;
                end else if (mv_right) begin
                    op_next    = OP_RIGHT;
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                test_x_next     = cur_pos_x;
                test_y_next     = cur_pos_y;
                test_rot_next   = cur_rot;
                test_valid_next = 1'b1;
                state_next      = S_WAIT;
                case (op_reg)
                    OP_DOWN:  test_y_next   = cur_pos_y + BITS_Y_POS'(1);
                    OP_LEFT:  test_x_next   = cur_pos_x - BITS_X_POS'(1);
                    OP_RIGHT: test_x_next   = cur_pos_x + BITS_X_POS'(1);
                    default:  test_rot_next = cur_rot + BITS_ROT'(1);
                endcase
            end
            S_WAIT: begin
                if (test_done) begin
                    test_valid_next = 1'b0;
                    if (test_ok) begin
                        state_next = S_COMMIT;
                    end else begin
                        case (op_reg)
                            OP_DOWN: state_next = S_LOCK;
`ifdef WALL_KICK_EN
                            OP_ROT:  state_next = (32'(kick_idx_reg) < NUM_KICKS) ? S_KICK : S_IDLE;
`endif
                            default: state_next = S_IDLE;
                        endcase
                    end
                end
            end
            S_COMMIT: begin
                // Hard drop chains straight into the next y+1 while the mode holds
                state_next = (op_reg == OP_DOWN && mode == MODE_DROP) ? S_ISSUE : S_IDLE;
            end
            S_LOCK: state_next = S_IDLE;
`ifdef WALL_KICK_EN
            S_KICK: begin
                test_x_next     = cur_pos_x + kick_off[kick_idx_reg[1:0]];
                test_y_next     = cur_pos_y;
                test_rot_next   = cur_rot + BITS_ROT'(1);
                test_valid_next = 1'b1;
                kick_idx_next   = kick_idx_reg + 3'd1;
                state_next      = S_WAIT;
            end
`endif
            default: state_next = S_IDLE;
        endcase

        if (state_reg != S_IDLE && game_clk) tick_pend_next = 1'b1;
    end

    assign test_pos_x = test_x_reg;
    assign test_pos_y = test_y_reg;
    assign test_rot   = test_rot_reg;
    assign test_valid = test_valid_reg;
    assign upd_valid  = (state_reg == S_COMMIT);
    assign lock       = (state_reg == S_LOCK);
    assign busy       = (state_reg != S_IDLE);

endmodule

// File: tb/tb_piece_move_sequencer.sv
// Bench for piece_move_sequencer: directed scenarios plus randomized requests checked
// against a move/kick model; honours WALL_KICK_EN the same way as the design.
module tb_piece_move_sequencer;
    localparam int NK = 4;
    localparam logic [1:0] M_IDLE = 2'd0, M_PLAY = 2'd1, M_DROP = 2'd2;
`ifdef WALL_KICK_EN
    localparam bit KICK_EN = 1'b1;
`else
    localparam bit KICK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] mode = M_IDLE;
    logic       game_clk = 0, mv_left = 0, mv_right = 0, mv_rot = 0;
    logic [3:0] cur_x = 0;
    logic [4:0] cur_y = 0;
    logic [1:0] cur_r = 0;
    logic [3:0] test_pos_x;
    logic [4:0] test_pos_y;
    logic [1:0] test_rot;
    logic       test_valid, test_done = 0, test_ok = 0, upd_valid, lock, busy;

    int total = 0, bad = 0;
    int n_upd, n_lock, n_both, n_unstable, wait_cnt, resp_delay;
    bit holding;
    logic [10:0] held;
    bit verdicts[$];
    logic [10:0] cands[$];

    always #5 clk = ~clk;

    piece_move_sequencer #(.BITS_X_POS(4), .BITS_Y_POS(5), .BITS_ROT(2), .NUM_KICKS(NK),
                           .MODE_BITS(2), .MODE_PLAY(M_PLAY), .MODE_DROP(M_DROP)) dut (
        .clk(clk), .rst(rst), .mode(mode), .game_clk(game_clk), .mv_left(mv_left),
        .mv_right(mv_right), .mv_rot(mv_rot), .cur_pos_x(cur_x), .cur_pos_y(cur_y),
        .cur_rot(cur_r), .test_pos_x(test_pos_x), .test_pos_y(test_pos_y), .test_rot(test_rot),
        .test_valid(test_valid), .test_done(test_done), .test_ok(test_ok),
        .upd_valid(upd_valid), .lock(lock), .busy(busy));

    function automatic logic [10:0] pk(input int x, input int y, input int r);
        return {4'(x), 5'(y), 2'(r)};
    endfunction

    task automatic clear_obs();
        n_upd = 0; n_lock = 0; n_both = 0; n_unstable = 0; wait_cnt = 0; holding = 0;
        verdicts.delete(); cands.delete();
    endtask

    // One clock: observe at the falling edge, update the committed piece, answer as checker
    task automatic cycle();
        logic [10:0] now_c;
        @(negedge clk);
        test_done = 0; test_ok = 0;
        now_c = {test_pos_x, test_pos_y, test_rot};
        if (upd_valid) begin
            n_upd++; cur_x = test_pos_x; cur_y = test_pos_y; cur_r = test_rot;
        end
        if (lock) n_lock++;
        if (upd_valid && lock) n_both++;
        if (test_valid) begin
            if (!holding) begin holding = 1; held = now_c; end
            else if (held != now_c) n_unstable++;
            if (verdicts.size() > 0) begin
                if (wait_cnt >= resp_delay) begin
                    test_done = 1; test_ok = verdicts.pop_front();
                    cands.push_back(now_c); wait_cnt = 0;
                end else wait_cnt++;
            end
        end else begin
            holding = 0; wait_cnt = 0;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic pulse(input int which);
        game_clk = (which == 0); mv_left = (which == 1); mv_right = (which == 2); mv_rot = (which == 3);
        cycle();
        game_clk = 0; mv_left = 0; mv_right = 0; mv_rot = 0;
    endtask

    task automatic test_reset();
        run(2);
        total++; if ({test_pos_x, test_pos_y, test_rot} !== 11'd0) begin bad++; $display("FAIL reset_test_pos: got %h expected 000", {test_pos_x, test_pos_y, test_rot}); end
        total++; if ({test_valid, upd_valid, lock, busy} !== 4'b0) begin bad++; $display("FAIL reset_flags: got %b expected 0000", {test_valid, upd_valid, lock, busy}); end
        rst = 0; cur_x = 9; cur_y = 17; cur_r = 2;
        run(3);
        total++; if ({test_pos_x, test_pos_y, test_rot} !== pk(9, 17, 2)) begin bad++; $display("FAIL idle_mode_follow: got %h expected %h", {test_pos_x, test_pos_y, test_rot}, pk(9, 17, 2)); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_mode_busy: got %b expected 0", busy); end
    endtask

    task automatic test_gravity();
        clear_obs(); mode = M_PLAY; resp_delay = 2;
        cur_x = 5; cur_y = 3; cur_r = 0; run(2);
        verdicts.push_back(1'b1);
        pulse(0); run(10);
        total++; if (cands.size() !== 1 || cands[0] !== pk(5, 4, 0)) begin bad++; $display("FAIL gravity_cand: got n=%0d %h expected n=1 %h", cands.size(), cands[0], pk(5, 4, 0)); end
        total++; if (n_upd !== 1 || n_lock !== 0) begin bad++; $display("FAIL gravity_pulses: got upd=%0d lock=%0d expected 1 0", n_upd, n_lock); end
        total++; if (n_unstable !== 0) begin bad++; $display("FAIL gravity_stable: got %0d changes expected 0", n_unstable); end
        total++; if ({test_pos_x, test_pos_y, test_rot} !== pk(5, 4, 0) || busy !== 1'b0) begin bad++; $display("FAIL gravity_after: got %h busy=%b expected %h busy=0", {test_pos_x, test_pos_y, test_rot}, busy, pk(5, 4, 0)); end
        $display("txn gravity cands=%0d upd=%0d lock=%0d", cands.size(), n_upd, n_lock);
    endtask

    task automatic test_lock();
        clear_obs(); resp_delay = 0;
        cur_x = 5; cur_y = 19; cur_r = 0; run(1);
        verdicts.push_back(1'b0);
        pulse(0); run(8);
        total++; if (n_lock !== 1 || n_upd !== 0) begin bad++; $display("FAIL lock_pulses: got lock=%0d upd=%0d expected 1 0", n_lock, n_upd); end
        total++; if (cands.size() !== 1 || cands[0] !== pk(5, 20, 0)) begin bad++; $display("FAIL lock_cand: got n=%0d %h expected n=1 %h", cands.size(), cands[0], pk(5, 20, 0)); end
        total++; if (busy !== 1'b0 || test_valid !== 1'b0) begin bad++; $display("FAIL lock_idle: got busy=%b valid=%b expected 0 0", busy, test_valid); end
        $display("txn lock cands=%0d upd=%0d lock=%0d", cands.size(), n_upd, n_lock);
    endtask

    task automatic test_priority();
        clear_obs(); resp_delay = 0;
        cur_x = 7; cur_y = 2; cur_r = 1; run(1);
        verdicts.push_back(1'b1); verdicts.push_back(1'b1); verdicts.push_back(1'b1);
        game_clk = 1; mv_left = 1; cycle(); mv_left = 0;
        cycle();
        cycle(); game_clk = 0;
        run(14);
        total++; if (cands.size() !== 2) begin bad++; $display("FAIL prio_count: got %0d expected 2", cands.size()); end
        total++; if (cands.size() >= 2 && (cands[0] !== pk(7, 3, 1) || cands[1] !== pk(7, 4, 1))) begin bad++; $display("FAIL prio_cands: got %h %h expected %h %h", cands[0], cands[1], pk(7, 3, 1), pk(7, 4, 1)); end
        total++; if (n_upd !== 2 || {cur_x, cur_y, cur_r} !== pk(7, 4, 1)) begin bad++; $display("FAIL prio_commit: got upd=%0d cur=%h expected 2 %h", n_upd, {cur_x, cur_y, cur_r}, pk(7, 4, 1)); end
        $display("txn priority cands=%0d upd=%0d lock=%0d", cands.size(), n_upd, n_lock);
    endtask

    task automatic test_kick();
        clear_obs(); resp_delay = 0;
        cur_x = 0; cur_y = 5; cur_r = 3; run(1);
        verdicts.push_back(1'b0); verdicts.push_back(1'b1);
        pulse(3); run(14);
        total++; if (cands.size() < 1 || cands[0] !== pk(0, 5, 0)) begin bad++; $display("FAIL kick_first: got n=%0d %h expected %h", cands.size(), cands[0], pk(0, 5, 0)); end
        if (KICK_EN) begin
            total++; if (cands.size() !== 2 || cands[1] !== pk(1, 5, 0)) begin bad++; $display("FAIL kick_second: got n=%0d %h expected n=2 %h", cands.size(), cands[1], pk(1, 5, 0)); end
            total++; if (n_upd !== 1 || {cur_x, cur_y, cur_r} !== pk(1, 5, 0)) begin bad++; $display("FAIL kick_commit: got upd=%0d cur=%h expected 1 %h", n_upd, {cur_x, cur_y, cur_r}, pk(1, 5, 0)); end
        end else begin
            total++; if (cands.size() !== 1 || n_upd !== 0 || n_lock !== 0) begin bad++; $display("FAIL rot_single: got n=%0d upd=%0d lock=%0d expected 1 0 0", cands.size(), n_upd, n_lock); end
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL kick_idle: got busy=%b expected 0", busy); end
        $display("txn rotate cands=%0d upd=%0d lock=%0d", cands.size(), n_upd, n_lock);
    endtask

    task automatic test_drop();
        clear_obs(); resp_delay = 0;
        cur_x = 4; cur_y = 10; cur_r = 2; run(1);
        for (int i = 0; i < 5; i++) verdicts.push_back(1'b1);
        verdicts.push_back(1'b0);
        mode = M_DROP;
        for (int i = 0; i < 80; i++) begin
            cycle();
            if (n_lock > 0) begin mode = M_PLAY; break; end
        end
        mode = M_PLAY;
        run(4);
        total++; if (n_upd !== 5 || n_lock !== 1 || n_both !== 0) begin bad++; $display("FAIL drop_pulses: got upd=%0d lock=%0d both=%0d expected 5 1 0", n_upd, n_lock, n_both); end
        total++; if (cands.size() !== 6 || cands[5] !== pk(4, 16, 2)) begin bad++; $display("FAIL drop_cands: got n=%0d last=%h expected 6 %h", cands.size(), cands[cands.size() - 1], pk(4, 16, 2)); end
        total++; if ({cur_x, cur_y, cur_r} !== pk(4, 15, 2) || busy !== 1'b0) begin bad++; $display("FAIL drop_final: got cur=%h busy=%b expected %h 0", {cur_x, cur_y, cur_r}, busy, pk(4, 15, 2)); end
        $display("txn drop cands=%0d upd=%0d lock=%0d", cands.size(), n_upd, n_lock);
    endtask

    task automatic test_reset_mid_and_wrap();
        clear_obs(); resp_delay = 0;
        cur_x = 3; cur_y = 3; cur_r = 3; run(1);
        pulse(0); cycle();
        pulse(0);
        total++; if (test_valid !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL rst_pre_wait: got valid=%b busy=%b expected 1 1", test_valid, busy); end
        rst = 1; #1;
        total++; if ({test_valid, upd_valid, lock, busy} !== 4'b0 || {test_pos_x, test_pos_y, test_rot} !== 11'd0) begin bad++; $display("FAIL rst_async: got flags=%b pos=%h expected 0 000", {test_valid, upd_valid, lock, busy}, {test_pos_x, test_pos_y, test_rot}); end
        run(2); rst = 0; run(2);
        clear_obs();
        cur_x = 15; cur_y = 6; cur_r = 1;
        verdicts.push_back(1'b1);
        pulse(2); run(8);
        total++; if (cands.size() !== 1 || cands[0] !== pk(0, 6, 1)) begin bad++; $display("FAIL wrap_right: got n=%0d %h expected n=1 %h", cands.size(), cands[0], pk(0, 6, 1)); end
        total++; if (n_upd !== 1 || cur_x !== 4'd0) begin bad++; $display("FAIL wrap_commit: got upd=%0d x=%0d expected 1 0", n_upd, cur_x); end
        $display("txn wrap cands=%0d upd=%0d lock=%0d", cands.size(), n_upd, n_lock);
    endtask

    task automatic test_random();
        int x, y, r, op, n_att, cx, cy, cr, fx, fy, fr, e_upd, e_lock;
        bit v;
        int offs[4];
        logic [10:0] exp_c[$];
        offs = '{1, -1, 2, -2};
        for (int t = 0; t < 40; t++) begin
            clear_obs(); exp_c.delete();
            resp_delay = $urandom_range(0, 2);
            x = $urandom_range(0, 15); y = $urandom_range(0, 31); r = $urandom_range(0, 3);
            op = $urandom_range(0, 3);
            cur_x = 4'(x); cur_y = 5'(y); cur_r = 2'(r);
            fx = x; fy = y; fr = r; e_upd = 0; e_lock = 0;
            n_att = (op == 3 && KICK_EN) ? 1 + NK : 1;
            for (int a = 0; a < n_att; a++) begin
                cx = x; cy = y; cr = r;
                case (op)
                    0: cy = (y + 1) % 32;
                    1: cx = (x + 15) % 16;
                    2: cx = (x + 1) % 16;
                    default: begin
                        cr = (r + 1) % 4;
                        if (a > 0) cx = (x + offs[a - 1] + 16) % 16;
                    end
                endcase
                v = 1'($urandom_range(0, 1));
                verdicts.push_back(v);
                exp_c.push_back(pk(cx, cy, cr));
                if (v) begin e_upd = 1; fx = cx; fy = cy; fr = cr; break; end
                if (op == 0) begin e_lock = 1; break; end
            end
            pulse(op); run(30);
            total++; if (cands.size() !== exp_c.size()) begin bad++; $display("FAIL rnd%0d_count: got %0d expected %0d", t, cands.size(), exp_c.size()); end
            for (int i = 0; i < exp_c.size() && i < cands.size(); i++) begin
                total++; if (cands[i] !== exp_c[i]) begin bad++; $display("FAIL rnd%0d_cand%0d: got %h expected %h", t, i, cands[i], exp_c[i]); end
            end
            total++; if (n_upd !== e_upd || n_lock !== e_lock || n_both !== 0) begin bad++; $display("FAIL rnd%0d_pulses: got upd=%0d lock=%0d expected %0d %0d", t, n_upd, n_lock, e_upd, e_lock); end
            total++; if ({cur_x, cur_y, cur_r} !== pk(fx, fy, fr) || busy !== 1'b0 || n_unstable !== 0) begin bad++; $display("FAIL rnd%0d_final: got cur=%h busy=%b unstable=%0d expected %h 0 0", t, {cur_x, cur_y, cur_r}, busy, n_unstable, pk(fx, fy, fr)); end
            $display("txn rnd%0d op=%0d cur=%h cands=%0d upd=%0d lock=%0d", t, op, pk(x, y, r), cands.size(), n_upd, n_lock);
        end
    endtask

    initial begin
        test_reset();
        test_gravity();
        test_lock();
        test_priority();
        test_kick();
        test_drop();
        test_reset_mid_and_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
